// File: rtl/ddr3_init_seq.sv
// DDR3 power-up / mode-register initialisation sequencer with periodic refresh scheduling.
// One shared down-counter times every wait; the refresh backlog saturates at 8 postponed refreshes.
module ddr3_init_seq #(
  parameter int unsigned DDR_ROW_BITS = 13,
  parameter int unsigned RESET_CYCLES = 20000,
  parameter int unsigned CKE_CYCLES   = 50000,
  parameter int unsigned TXPR_CYCLES  = 17,
  parameter int unsigned TMRD_CYCLES  = 4,
  parameter int unsigned TMOD_CYCLES  = 12,
  parameter int unsigned TZQ_CYCLES   = 512,
  parameter int unsigned TRP_CYCLES   = 2,
  parameter int unsigned TREFI_CYCLES = 780,
  parameter logic [DDR_ROW_BITS-1:0] MR0 = DDR_ROW_BITS'(13'h0520),
  parameter logic [DDR_ROW_BITS-1:0] MR1 = DDR_ROW_BITS'(13'h0004),
  parameter logic [DDR_ROW_BITS-1:0] MR2 = DDR_ROW_BITS'(13'h0000),
  parameter logic [DDR_ROW_BITS-1:0] MR3 = DDR_ROW_BITS'(13'h0000)
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    dfi_rst_no,
  output logic                    dfi_cke_o,
  output logic                    cfg_run_o,
  output logic                    cfg_req_o,
  input  logic                    cfg_rdy_i,
  output logic [2:0]              cfg_cmd_o,
  output logic [2:0]              cfg_ba_o,
  output logic [DDR_ROW_BITS-1:0] cfg_adr_o,
  output logic                    ref_req_o,
  input  logic                    ref_ack_i,
  output logic                    ref_urgent_o
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PEND_W   = 4;
  localparam int unsigned PEND_MAX = 8;

  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_ZQCL = 3'b110;
  localparam logic [2:0] CMD_NOP  = 3'b111;

  localparam logic [DDR_ROW_BITS-1:0] ADR_A10 = DDR_ROW_BITS'(1024);

  typedef enum logic [3:0] {
    S_RST, S_CKELO, S_XPR, S_MR2, S_MR3, S_MR1, S_MR0, S_ZQCL, S_PREA, S_RUN
  } state_e;

  // Counter load value for a wait of n cycles
  function automatic logic [CNT_W-1:0] ld(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rst_n_q, rst_n_d;
  logic                    cke_q, cke_d;
  logic                    run_q, run_d;
  logic                    req_q, req_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [2:0]              ba_q, ba_d;
  logic [DDR_ROW_BITS-1:0] adr_q, adr_d;
  logic [PEND_W-1:0]       pend_q, pend_d;
  logic                    ref_req_q, ref_req_d;
  logic                    urgent_q, urgent_d;

  logic                    cnt_zero;
  logic [CNT_W-1:0]        cnt_dec;
  state_e                  cmd_next;
  logic [CNT_W-1:0]        wait_ld;

  // Successor and post-command wait for each command state
  always_comb begin
    cmd_next = S_RUN;
    wait_ld  = '0;
    case (state_q)
      S_MR2:   begin cmd_next = S_MR3;  wait_ld = ld(TMRD_CYCLES); end
      S_MR3:   begin cmd_next = S_MR1;  wait_ld = ld(TMRD_CYCLES); end
      S_MR1:   begin cmd_next = S_MR0;  wait_ld = ld(TMRD_CYCLES); end
      S_MR0:   begin cmd_next = S_ZQCL; wait_ld = ld(TMOD_CYCLES); end
      S_ZQCL:  begin cmd_next = S_PREA; wait_ld = ld(TZQ_CYCLES);  end
      S_PREA:  begin cmd_next = S_RUN;  wait_ld = ld(TRP_CYCLES);  end
      default: begin cmd_next = S_RUN;  wait_ld = '0;              end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rst_n_d  = rst_n_q;
    cke_d    = cke_q;
    run_d    = run_q;
    req_d    = req_q;
    cmd_d    = cmd_q;
    ba_d     = ba_q;
    adr_d    = adr_q;
    pend_d   = pend_q;
    cnt_zero = (cnt_q == '0);
    cnt_dec  = cnt_q - CNT_W'(1);

    case (state_q)
      S_RST: begin
        if (cnt_zero) begin
          state_d = S_CKELO;
          rst_n_d = 1'b1;
          cnt_d   = ld(CKE_CYCLES);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_CKELO: begin
        if (cnt_zero) begin
          state_d = S_XPR;
          cke_d   = 1'b1;
          cnt_d   = ld(TXPR_CYCLES);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_XPR: begin
        if (cnt_zero) state_d = S_MR2;
        else          cnt_d   = cnt_dec;
      end
      // req_q high: issue phase; req_q low: post-command wait
      S_MR2, S_MR3, S_MR1, S_MR0, S_ZQCL, S_PREA: begin
        if (req_q) begin
          if (cfg_rdy_i) begin
            req_d = 1'b0;
            cmd_d = CMD_NOP;
            ba_d  = '0;
            adr_d = '0;
            cnt_d = wait_ld;
          end
        end else if (cnt_zero) begin
          state_d = cmd_next;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RUN: begin
        cnt_d = cnt_zero ? ld(TREFI_CYCLES) : cnt_dec;
        if (cnt_zero && !ref_ack_i) begin
          if (pend_q != PEND_W'(PEND_MAX)) pend_d = pend_q + PEND_W'(1);
        end else if (!cnt_zero && ref_ack_i && (pend_q != '0)) begin
          pend_d = pend_q - PEND_W'(1);
        end
      end
      default: state_d = S_RST;
    endcase

    // Entry actions: present the next command or start the refresh timer
    if (state_d != state_q) begin
      case (state_d)
        S_MR2:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd2; adr_d = MR2;     end
        S_MR3:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd3; adr_d = MR3;     end
        S_MR1:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd1; adr_d = MR1;     end
        S_MR0:  begin req_d = 1'b1; cmd_d = CMD_MRS;  ba_d = 3'd0; adr_d = MR0;     end
        S_ZQCL: begin req_d = 1'b1; cmd_d = CMD_ZQCL; ba_d = 3'd0; adr_d = ADR_A10; end
        S_PREA: begin req_d = 1'b1; cmd_d = CMD_PRE;  ba_d = 3'd0; adr_d = ADR_A10; end
        S_RUN:  begin run_d = 1'b1; cnt_d = ld(TREFI_CYCLES);                        end
        default: ;
      endcase
    end

    ref_req_d = (pend_d != '0);
    urgent_d  = (pend_d == PEND_W'(PEND_MAX));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_RST;
      cnt_q     <= ld(RESET_CYCLES);
      rst_n_q   <= 1'b0;
      cke_q     <= 1'b0;
      run_q     <= 1'b0;
      req_q     <= 1'b0;
      cmd_q     <= CMD_NOP;
      ba_q      <= '0;
      adr_q     <= '0;
      pend_q    <= '0;
      ref_req_q <= 1'b0;
      urgent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_n_q   <= rst_n_d;
      cke_q     <= cke_d;
      run_q     <= run_d;
      req_q     <= req_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      adr_q     <= adr_d;
      pend_q    <= pend_d;
      ref_req_q <= ref_req_d;
      urgent_q  <= urgent_d;
    end
  end

  assign dfi_rst_no   = rst_n_q;
  assign dfi_cke_o    = cke_q;
  assign cfg_run_o    = run_q;
  assign cfg_req_o    = req_q;
  assign cfg_cmd_o    = cmd_q;
  assign cfg_ba_o     = ba_q;
  assign cfg_adr_o    = adr_q;
  assign ref_req_o    = ref_req_q;
  assign ref_urgent_o = urgent_q;

endmodule
